// File: rtl/sram_arbiter.sv
// Arbitrates one external 8-bit async SRAM between the AVR CPU port and a DMA requester.
// Each access runs IDLE -> ACCESS (ACCESS_CYCLES) -> HOLD with round-robin grant on contention.
module sram_arbiter #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [7:0]        cpu_d_out,
    output logic [7:0]        cpu_d_in,
    input  logic              cpu_cs,
    input  logic              cpu_oe,
    input  logic              cpu_we,
    output logic              cpu_wait,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic [7:0]        dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t            r_state,  w_state;
    logic              r_owner,  w_owner;
    logic              r_last,   w_last;
    logic              r_we,     w_we;
    logic [CNT_W-1:0]  r_cnt,    w_cnt;
    logic [ADDR_W-1:0] r_addr,   w_addr;
    logic [7:0]        r_wdata,  w_wdata;
    logic              r_ce_n,   w_ce_n;
    logic              r_oe_n,   w_oe_n;
    logic              r_we_n,   w_we_n;
    logic              r_dq_oe,  w_dq_oe;
    logic [7:0]        r_cpu_rd, w_cpu_rd;
    logic [7:0]        r_dma_rd, w_dma_rd;
    logic              r_ack,    w_ack;
    logic              w_grant_dma;

    // Read strobe is implied by cs & ~we, so cpu_oe carries no extra information.
    logic w_unused;
    assign w_unused = cpu_oe;

    // State and registered pad/requester outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_owner  <= OWN_CPU;
            r_last   <= OWN_DMA;
            r_we     <= 1'b0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
            r_cpu_rd <= '0;
            r_dma_rd <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_owner  <= w_owner;
            r_last   <= w_last;
            r_we     <= w_we;
            r_cnt    <= w_cnt;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_ce_n   <= w_ce_n;
            r_oe_n   <= w_oe_n;
            r_we_n   <= w_we_n;
            r_dq_oe  <= w_dq_oe;
            r_cpu_rd <= w_cpu_rd;
            r_dma_rd <= w_dma_rd;
            r_ack    <= w_ack;
        end
    end

    // Next state plus next-cycle strobe values, so pad strobes line up with the state.
    always_comb begin
        w_state     = r_state;
        w_owner     = r_owner;
        w_last      = r_last;
        w_we        = r_we;
        w_cnt       = r_cnt;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_ce_n      = r_ce_n;
        w_oe_n      = r_oe_n;
        w_we_n      = r_we_n;
        w_dq_oe     = r_dq_oe;
        w_cpu_rd    = r_cpu_rd;
        w_dma_rd    = r_dma_rd;
        w_ack       = 1'b0;
        w_grant_dma = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ce_n  = 1'b1;
                w_oe_n  = 1'b1;
                w_we_n  = 1'b1;
                w_dq_oe = 1'b0;
                if (cpu_cs || dma_req) begin
                    if (cpu_cs && dma_req) begin
                        w_grant_dma = (r_last == OWN_CPU);
                    end else begin
                        w_grant_dma = dma_req;
                    end
                    w_owner = w_grant_dma;
                    w_last  = w_grant_dma;
                    w_we    = w_grant_dma ? dma_we    : cpu_we;
                    w_addr  = w_grant_dma ? dma_addr  : cpu_a;
                    w_wdata = w_grant_dma ? dma_wdata : cpu_d_out;
                    w_cnt   = '0;
                    w_state = ST_ACCESS;
                    w_ce_n  = 1'b0;
                    w_oe_n  = w_we;
                    w_we_n  = ~w_we;
                    w_dq_oe = w_we;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == CNT_LAST) begin
                    w_state = ST_HOLD;
                    w_oe_n  = 1'b1;
                    w_we_n  = 1'b1;
                    w_ack   = (r_owner == OWN_DMA);
                    if (!r_we) begin
                        if (r_owner == OWN_DMA) begin
                            w_dma_rd = sram_dq_i;
                        end else begin
                            w_cpu_rd = sram_dq_i;
                        end
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                w_state = ST_IDLE;
                w_ce_n  = 1'b1;
                w_oe_n  = 1'b1;
                w_we_n  = 1'b1;
                w_dq_oe = 1'b0;
            end
            default: begin
                w_state = ST_IDLE;
                w_ce_n  = 1'b1;
                w_oe_n  = 1'b1;
                w_we_n  = 1'b1;
                w_dq_oe = 1'b0;
            end
        endcase
    end

    assign cpu_wait   = cpu_cs & ~((r_state == ST_HOLD) & (r_owner == OWN_CPU));
    assign cpu_d_in   = r_cpu_rd;
    assign dma_rdata  = r_dma_rd;
    assign dma_ack    = r_ack;
    assign sram_addr  = r_addr;
    assign sram_dq_o  = r_wdata;
    assign sram_dq_oe = r_dq_oe;
    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed CPU/DMA accesses against a behavioural SRAM.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d_out, cpu_d_in;
    logic        cpu_cs, cpu_oe, cpu_we, cpu_wait;
    logic        dma_req, dma_we, dma_ack;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [15:0] sram_addr;
    logic [7:0]  sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic [15:0] cpu_a1;
    logic [7:0]  cpu_d_out1, cpu_d_in1;
    logic        cpu_cs1, cpu_oe1, cpu_we1, cpu_wait1;
    logic        dma_req1, dma_we1, dma_ack1;
    logic [15:0] dma_addr1;
    logic [7:0]  dma_wdata1, dma_rdata1;
    logic [15:0] sram_addr1;
    logic [7:0]  sram_dq_o1, sram_dq_i1;
    logic        sram_dq_oe1, sram_ce_n1, sram_oe_n1, sram_we_n1;

    logic [7:0] mem  [0:65535];
    logic [7:0] mem1 [0:65535];

    assign sram_dq_i  = (!sram_ce_n  && !sram_oe_n)  ? mem[sram_addr]   : 8'h00;
    assign sram_dq_i1 = (!sram_ce_n1 && !sram_oe_n1) ? mem1[sram_addr1] : 8'h00;

    sram_arbiter #(.ADDR_W(16), .ACCESS_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_a(cpu_a), .cpu_d_out(cpu_d_out), .cpu_d_in(cpu_d_in),
        .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_wait(cpu_wait),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    sram_arbiter #(.ADDR_W(16), .ACCESS_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_a(cpu_a1), .cpu_d_out(cpu_d_out1), .cpu_d_in(cpu_d_in1),
        .cpu_cs(cpu_cs1), .cpu_oe(cpu_oe1), .cpu_we(cpu_we1), .cpu_wait(cpu_wait1),
        .dma_req(dma_req1), .dma_we(dma_we1), .dma_addr(dma_addr1),
        .dma_wdata(dma_wdata1), .dma_rdata(dma_rdata1), .dma_ack(dma_ack1),
        .sram_addr(sram_addr1), .sram_dq_o(sram_dq_o1), .sram_dq_oe(sram_dq_oe1),
        .sram_dq_i(sram_dq_i1), .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1),
        .sram_we_n(sram_we_n1)
    );

    typedef struct packed {
        logic       is_dma;
        logic       we;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_ce = 0, n_we = 0, n_dqoe = 0, n_ack = 0;
    int   s_ce, s_we, s_dqoe, s_ack, nw, nd;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic is_dma;
        forever begin
            @(negedge clk);
            if (!rst && (dma_ack || (cpu_cs && !cpu_wait))) begin
                is_dma = dma_ack;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_completion", 32'(is_dma), 32'(!is_dma));
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_owner", 32'(is_dma), 32'(e.is_dma));
                    if (!e.we) chk("sb_rdata", 32'(is_dma ? dma_rdata : cpu_d_in), 32'(e.data));
                end
            end
        end
    endtask

    task automatic cpu_op(input logic [15:0] a, input logic we, input logic [7:0] d, output int nwait);
        cpu_a = a; cpu_we = we; cpu_oe = ~we; cpu_d_out = d; cpu_cs = 1'b1;
        nwait = 0;
        @(negedge clk);
        while (cpu_wait && nwait < 64) begin
            nwait++;
            @(negedge clk);
        end
        if (cpu_wait) chk("cpu_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        cpu_cs = 1'b0; cpu_oe = 1'b0;
    endtask

    task automatic dma_op(input logic [15:0] a, input logic we, input logic [7:0] d, output int n);
        dma_addr = a; dma_we = we; dma_wdata = d; dma_req = 1'b1;
        n = 1;
        @(negedge clk);
        while (!dma_ack && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (!dma_ack) chk("dma_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        dma_req = 1'b0;
    endtask

    task automatic snap();
        s_ce = n_ce; s_we = n_we; s_dqoe = n_dqoe; s_ack = n_ack;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]  = pat(16'(i));
            mem1[i] = 8'h00;
        end
        mem[16'h1234] = 8'hA5;
        rst = 1'b1;
        cpu_a = '0; cpu_d_out = '0; cpu_cs = 0; cpu_oe = 0; cpu_we = 0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        cpu_a1 = '0; cpu_d_out1 = '0; cpu_cs1 = 0; cpu_oe1 = 0; cpu_we1 = 0;
        dma_req1 = 0; dma_we1 = 0; dma_addr1 = '0; dma_wdata1 = '0;

        fork
            monitor();
            forever begin
                @(negedge clk);
                if (!sram_ce_n) n_ce++;
                if (!sram_we_n) n_we++;
                if (sram_dq_oe) n_dqoe++;
                if (dma_ack)    n_ack++;
            end
            forever begin
                @(posedge clk);
                if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] = sram_dq_o;
                if (!sram_ce_n1 && !sram_we_n1 && sram_dq_oe1) mem1[sram_addr1] = sram_dq_o1;
            end
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'b1110);
        chk("rst_addr_data", 32'({sram_addr, sram_dq_o}), 32'd0);
        chk("rst_rdata", 32'({cpu_d_in, dma_rdata, dma_ack, cpu_wait}), 32'd0);
        rst = 1'b0;

        // CPU read with wait-state profile.
        snap();
        exp_q.push_back('{is_dma: 1'b0, we: 1'b0, data: 8'hA5});
        cpu_op(16'h1234, 1'b0, 8'h00, nw);
        chk("t1_wait_cycles", 32'(nw), 32'd3);
        chk("t1_ce_low_cycles", 32'(n_ce - s_ce), 32'd3);
        chk("t1_cpu_d_in", 32'(cpu_d_in), 32'hA5);

        // DMA write with strobe widths and ack timing.
        snap();
        exp_q.push_back('{is_dma: 1'b1, we: 1'b1, data: 8'h00});
        dma_op(16'h0100, 1'b1, 8'h3C, nd);
        chk("t2_ack_cycle", 32'(nd), 32'd4);
        chk("t2_we_low_cycles", 32'(n_we - s_we), 32'd2);
        chk("t2_dqoe_cycles", 32'(n_dqoe - s_dqoe), 32'd3);
        chk("t2_ack_pulses", 32'(n_ack - s_ack), 32'd1);
        chk("t2_mem", 32'(mem[16'h0100]), 32'h3C);

        // Simultaneous requests after reset: CPU first, then strict alternation.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back('{is_dma: 1'b0, we: 1'b0, data: pat(16'h2000)});
        exp_q.push_back('{is_dma: 1'b1, we: 1'b0, data: pat(16'h3000)});
        exp_q.push_back('{is_dma: 1'b0, we: 1'b0, data: pat(16'h2001)});
        exp_q.push_back('{is_dma: 1'b1, we: 1'b0, data: pat(16'h3001)});
        fork
            begin
                int w;
                cpu_op(16'h2000, 1'b0, 8'h00, w);
                cpu_op(16'h2001, 1'b0, 8'h00, w);
            end
            begin
                int d;
                dma_op(16'h3000, 1'b0, 8'h00, d);
                dma_op(16'h3001, 1'b0, 8'h00, d);
            end
        join
        chk("t3_queue_drained", 32'(exp_q.size()), 32'd0);

        // DMA read stream: one ack every 4 cycles.
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back('{is_dma: 1'b1, we: 1'b0, data: pat(16'h4000 + 16'(i))});
            dma_op(16'h4000 + 16'(i), 1'b0, 8'h00, nd);
            chk("t4_ack_period", 32'(nd), 32'd4);
        end

        // CPU write leaves cpu_d_in untouched.
        exp_q.push_back('{is_dma: 1'b0, we: 1'b1, data: 8'h00});
        cpu_op(16'h5000, 1'b1, 8'h11, nw);
        chk("t7_mem", 32'(mem[16'h5000]), 32'h11);
        chk("t7_cpu_d_in_held", 32'(cpu_d_in), 32'(pat(16'h2001)));
        chk("t7_dma_rdata_held", 32'(dma_rdata), 32'(pat(16'h400F)));

        // Reset in the middle of a DMA write access.
        snap();
        dma_addr = 16'h0200; dma_we = 1'b1; dma_wdata = 8'h77; dma_req = 1'b1;
        @(posedge clk); #1;
        chk("t5_access_started", 32'(sram_ce_n), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'b1110);
        chk("t5_rst_no_ack", 32'(dma_ack), 32'd0);
        exp_q.push_back('{is_dma: 1'b1, we: 1'b1, data: 8'h00});
        rst = 1'b0;
        nd = 1;
        @(negedge clk);
        while (!dma_ack && nd < 64) begin
            nd++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        dma_req = 1'b0;
        chk("t5_reserve_ack_cycle", 32'(nd), 32'd4);
        chk("t5_total_acks", 32'(n_ack - s_ack), 32'd1);
        chk("t5_mem", 32'(mem[16'h0200]), 32'h77);

        // Single-cycle access build: CPU write stalls for two cycles.
        cpu_a1 = 16'h0055; cpu_we1 = 1'b1; cpu_d_out1 = 8'hC3; cpu_cs1 = 1'b1;
        nw = 0;
        @(negedge clk);
        while (cpu_wait1 && nw < 64) begin
            nw++;
            @(negedge clk);
        end
        chk("t6_hold_strobes", 32'({sram_ce_n1, sram_we_n1, sram_dq_oe1}), 32'b011);
        @(posedge clk); #1;
        cpu_cs1 = 1'b0;
        chk("t6_wait_cycles", 32'(nw), 32'd2);
        chk("t6_mem", 32'(mem1[16'h0055]), 32'hC3);

        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
